// File: rtl/serializator_sieci.sv
// serializator_sieci: back-end for the 6-input sorting network.
// It captures six sorted words in one load and streams them out one word per
// cycle under a valid/ready handshake. Each word carries its rank and a
// last-word flag. Back-to-back frames run without an idle cycle.
// Optional feature (macro SORT_CHECK_EN): flags loads whose words are not in
// non-decreasing order through the registered output blad_kolejnosci.
module serializator_sieci #(
  parameter int SZER      = 4,
  parameter int LICZ_SZER = 8
) (
  input  logic                 zegar,
  input  logic                 reset_n,
  input  logic [SZER-1:0]      wejscie_0,
  input  logic [SZER-1:0]      wejscie_1,
  input  logic [SZER-1:0]      wejscie_2,
  input  logic [SZER-1:0]      wejscie_3,
  input  logic [SZER-1:0]      wejscie_4,
  input  logic [SZER-1:0]      wejscie_5,
  input  logic                 wejscie_wazne,
  output logic                 wejscie_gotowe,
  output logic [SZER-1:0]      wyjscie_dane,
  output logic [2:0]           wyjscie_indeks,
  output logic                 wyjscie_ostatni,
  output logic                 wyjscie_wazne,
  input  logic                 wyjscie_gotowe_odb,
`ifdef SORT_CHECK_EN
  output logic                 blad_kolejnosci,
`endif
  output logic [LICZ_SZER-1:0] licznik_ramek
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stan_t;

  localparam logic [2:0] OSTATNI_INDEKS = 3'd5;

  stan_t           stan, stan_nast;
  logic [SZER-1:0] bufor [6];
  logic [SZER-1:0] wej   [6];
  logic [2:0]      indeks, indeks_nast;
  logic            zaladuj;
  logic            transfer;
  logic            koniec_ramki;

  // Gather the six network outputs so the buffer can be loaded in one loop.
  assign wej[0] = wejscie_0;
  assign wej[1] = wejscie_1;
  assign wej[2] = wejscie_2;
  assign wej[3] = wejscie_3;
  assign wej[4] = wejscie_4;
  assign wej[5] = wejscie_5;

  // Output view of the current word: everything derives from registered state,
  // so dane/indeks/ostatni cannot move while downstream stalls.
  assign wyjscie_wazne   = (stan == SEND);
  assign wyjscie_dane    = bufor[indeks];
  assign wyjscie_indeks  = indeks;
  assign wyjscie_ostatni = wyjscie_wazne && (indeks == OSTATNI_INDEKS);

  assign transfer = wyjscie_wazne && wyjscie_gotowe_odb;
  assign zaladuj  = wejscie_wazne && wejscie_gotowe;

  // Load acceptance: always free in IDLE; in SEND only when the last word is
  // leaving this very cycle (combinational path from wyjscie_gotowe_odb).
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    wejscie_gotowe = 1'b0;
    if (reset_n) begin
      case (stan)
        IDLE:    wejscie_gotowe = 1'b1;
        SEND:    wejscie_gotowe = (indeks == OSTATNI_INDEKS) && wyjscie_gotowe_odb;
        default: wejscie_gotowe = 1'b0;
      endcase
    end
  end

  // Next-state and next-index decision for the streaming FSM.
  always_comb begin
    stan_nast    = stan;
    indeks_nast  = indeks;
    koniec_ramki = 1'b0;
    case (stan)
      IDLE: begin
        if (zaladuj) begin
          stan_nast   = SEND;
          indeks_nast = 3'd0;
        end
      end
      SEND: begin
        if (transfer) begin
          if (indeks == OSTATNI_INDEKS) begin
            koniec_ramki = 1'b1;
            indeks_nast  = 3'd0;
            stan_nast    = zaladuj ? SEND : IDLE;
          end else begin
            indeks_nast = indeks + 3'd1;
          end
        end
      end
      default: begin
        stan_nast   = IDLE;
        indeks_nast = 3'd0;
      end
    endcase
  end

  // State, index and frame counter registers.
  always_ff @(posedge zegar or negedge reset_n) begin
    if (!reset_n) begin
      stan          <= IDLE;
      indeks        <= 3'd0;
      licznik_ramek <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      stan   <= stan_nast;
      indeks <= indeks_nast;
      if (koniec_ramki) begin
        licznik_ramek <= licznik_ramek + 1'b1;
      end
    end
  end

  // Six-entry frame buffer, written as a whole on every accepted load.
  always_ff @(posedge zegar or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the buffer is small and its contents are visible on wyjscie_dane,
      // so it is cleared on reset rather than left as an unreset memory.
      for (int k = 0; k < 6; k++) begin
        bufor[k] <= '0;
      end
    end else if (zaladuj) begin
      for (int k = 0; k < 6; k++) begin
        bufor[k] <= wej[k];
      end
    end
  end

`ifdef SORT_CHECK_EN
  logic       naruszenie;
  logic [2:0] blad_licz;

  // Order check on the incoming words: any adjacent pair descending is a fault.
  always_comb begin
    naruszenie = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (wej[k] > wej[k+1]) begin
        naruszenie = 1'b1;
      end
    end
  end

  // Error flag follows the most recent load; the counter saturates at 7.
  always_ff @(posedge zegar or negedge reset_n) begin
    if (!reset_n) begin
      blad_kolejnosci <= 1'b0;
      blad_licz       <= 3'd0;
    end else if (zaladuj) begin
      blad_kolejnosci <= naruszenie;
      if (naruszenie && (blad_licz != 3'd7)) begin
        blad_licz <= blad_licz + 3'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serializator_sieci.sv
// Self-checking bench for serializator_sieci: directed scenarios followed by
// randomized traffic, all compared against a queue-based frame model.
// Define SORT_CHECK_EN for both bench and RTL to cover blad_kolejnosci.
module tb_serializator_sieci;

  localparam int SZER      = 4;
  localparam int LICZ_SZER = 8;

  logic                 zegar;
  logic                 reset_n;
  logic [SZER-1:0]      wejscie_0, wejscie_1, wejscie_2;
  logic [SZER-1:0]      wejscie_3, wejscie_4, wejscie_5;
  logic                 wejscie_wazne;
  logic                 wejscie_gotowe;
  logic [SZER-1:0]      wyjscie_dane;
  logic [2:0]           wyjscie_indeks;
  logic                 wyjscie_ostatni;
  logic                 wyjscie_wazne;
  logic                 wyjscie_gotowe_odb;
  logic [LICZ_SZER-1:0] licznik_ramek;
`ifdef SORT_CHECK_EN
  logic                 blad_kolejnosci;
`endif

  serializator_sieci #(.SZER(SZER), .LICZ_SZER(LICZ_SZER)) dut (
    .zegar              (zegar),
    .reset_n            (reset_n),
    .wejscie_0          (wejscie_0),
    .wejscie_1          (wejscie_1),
    .wejscie_2          (wejscie_2),
    .wejscie_3          (wejscie_3),
    .wejscie_4          (wejscie_4),
    .wejscie_5          (wejscie_5),
    .wejscie_wazne      (wejscie_wazne),
    .wejscie_gotowe     (wejscie_gotowe),
    .wyjscie_dane       (wyjscie_dane),
    .wyjscie_indeks     (wyjscie_indeks),
    .wyjscie_ostatni    (wyjscie_ostatni),
    .wyjscie_wazne      (wyjscie_wazne),
    .wyjscie_gotowe_odb (wyjscie_gotowe_odb),
`ifdef SORT_CHECK_EN
    .blad_kolejnosci    (blad_kolejnosci),
`endif
    .licznik_ramek      (licznik_ramek)
  );

  initial zegar = 1'b0;
  always #5 zegar = ~zegar;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words still to be streamed in the current frame (head is
  // the word on the output), completed-frame total and expected order flag.
  logic [SZER-1:0] q[$];
  int              frames   = 0;
  bit              flag_exp = 1'b0;

  // Stimulus for the next cycle.
  logic [SZER-1:0] tw [6];
  logic            tv;
  logic            todb;

  function automatic bit unsorted(input logic [SZER-1:0] a [6]);
    bit r = 1'b0;
    for (int k = 0; k < 5; k++) if (a[k] > a[k+1]) r = 1'b1;
    return r;
  endfunction

  task automatic set_w(input logic [SZER-1:0] a, b, c, d, e, f);
    tw[0] = a; tw[1] = b; tw[2] = c; tw[3] = d; tw[4] = e; tw[5] = f;
  endtask

  // One clock cycle: drive on the falling edge, compare, then advance the model
  // at the rising edge.
  task automatic krok();
    bit got_exp;
    bit xfer;
    @(negedge zegar);
    wejscie_0 = tw[0]; wejscie_1 = tw[1]; wejscie_2 = tw[2];
    wejscie_3 = tw[3]; wejscie_4 = tw[4]; wejscie_5 = tw[5];
    wejscie_wazne      = tv;
    wyjscie_gotowe_odb = todb;
    #1;
    got_exp = (q.size() == 0) || (q.size() == 1 && todb);
    check("wazne",   32'(wyjscie_wazne),   32'(q.size() > 0));
    check("gotowe",  32'(wejscie_gotowe),  32'(got_exp));
    check("ostatni", 32'(wyjscie_ostatni), 32'(q.size() == 1));
    check("licznik", 32'(licznik_ramek),   32'(frames % (1 << LICZ_SZER)));
    if (q.size() > 0) begin
      check("dane",   32'(wyjscie_dane),   32'(q[0]));
      check("indeks", 32'(wyjscie_indeks), 32'(6 - q.size()));
    end
`ifdef SORT_CHECK_EN
    check("blad", 32'(blad_kolejnosci), 32'(flag_exp));
`endif
    @(posedge zegar);
    xfer = (q.size() > 0) && todb;
    if (xfer) begin
      void'(q.pop_front());
      if (q.size() == 0) frames++;
    end
    if (tv && got_exp) begin
      for (int k = 0; k < 6; k++) q.push_back(tw[k]);
      flag_exp = unsorted(tw);
    end
  endtask

  task automatic idle_cycles(input int n);
    tv = 1'b0; todb = 1'b1;
    for (int i = 0; i < n; i++) krok();
  endtask

  // Load the frame in tw, then let it drain with downstream always ready.
  task automatic whole_frame();
    tv = 1'b1; todb = 1'b1;
    krok();
    tv = 1'b0;
    for (int i = 0; i < 6; i++) krok();
  endtask

  initial begin
    reset_n = 1'b0;
    tv = 1'b0; todb = 1'b0;
    set_w(0, 0, 0, 0, 0, 0);
    wejscie_0 = '0; wejscie_1 = '0; wejscie_2 = '0;
    wejscie_3 = '0; wejscie_4 = '0; wejscie_5 = '0;
    wejscie_wazne = 1'b0; wyjscie_gotowe_odb = 1'b1;
    #12;
    check("rst_wazne",   32'(wyjscie_wazne),   32'd0);
    check("rst_gotowe",  32'(wejscie_gotowe),  32'd0);
    check("rst_dane",    32'(wyjscie_dane),    32'd0);
    check("rst_indeks",  32'(wyjscie_indeks),  32'd0);
    check("rst_ostatni", 32'(wyjscie_ostatni), 32'd0);
    check("rst_licznik", 32'(licznik_ramek),   32'd0);
    @(negedge zegar);
    reset_n = 1'b1;

    // Basic frame with downstream always ready.
    set_w(1, 2, 3, 5, 7, 9);
    whole_frame();
    idle_cycles(2);

    // Backpressure for three cycles while indeks 2 is on the output.
    tv = 1'b1; todb = 1'b1; krok();
    tv = 1'b0; krok(); krok();
    todb = 1'b0; krok(); krok(); krok();
    todb = 1'b1;
    for (int i = 0; i < 4; i++) krok();
    idle_cycles(1);

    // Back-to-back: B held on the input the whole time, accepted only as A's
    // last word leaves; A's middle words must not be overwritten.
    set_w(0, 0, 1, 1, 2, 4'hF);
    tv = 1'b1; todb = 1'b1; krok();
    set_w(4, 4, 4, 4, 4, 4);
    for (int i = 0; i < 6; i++) krok();
    tv = 1'b0;
    for (int i = 0; i < 6; i++) krok();
    idle_cycles(1);

    // Ignored load carrying different data at A's indeks 2.
    set_w(0, 0, 1, 1, 2, 4'hF);
    tv = 1'b1; krok();
    tv = 1'b0; krok(); krok();
    set_w(4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9);
    tv = 1'b1; krok();
    tv = 1'b0;
    for (int i = 0; i < 3; i++) krok();
    idle_cycles(1);

`ifdef SORT_CHECK_EN
    // Out-of-order load flags the error; a sorted load clears it.
    set_w(3, 2, 4, 5, 6, 7);
    whole_frame();
    set_w(0, 1, 2, 3, 4, 5);
    whole_frame();
    idle_cycles(1);
`endif

    // Reset in the middle of a frame, away from any clock edge.
    set_w(6, 7, 8, 9, 10, 11);
    tv = 1'b1; todb = 1'b1; krok();
    tv = 1'b0; krok(); krok(); krok();
    @(negedge zegar);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_wazne",   32'(wyjscie_wazne),   32'd0);
    check("mid_rst_licznik", 32'(licznik_ramek),   32'd0);
    check("mid_rst_gotowe",  32'(wejscie_gotowe),  32'd0);
    check("mid_rst_dane",    32'(wyjscie_dane),    32'd0);
    check("mid_rst_indeks",  32'(wyjscie_indeks),  32'd0);
    check("mid_rst_ostatni", 32'(wyjscie_ostatni), 32'd0);
    q.delete();
    frames   = 0;
    flag_exp = 1'b0;
    @(negedge zegar);
    reset_n = 1'b1;
    set_w(4'hF, 0, 4'hF, 0, 4'hF, 0);
    whole_frame();

    // Long back-to-back run to wrap the frame counter.
    tv = 1'b1; todb = 1'b1;
    for (int f = 0; f < 262; f++) begin
      for (int k = 0; k < 6; k++) tw[k] = SZER'($urandom);
      for (int i = 0; i < 6; i++) krok();
    end
    tv = 1'b0;
    for (int i = 0; i < 7; i++) krok();

    // Randomized traffic: random loads, random stalls, half the frames sorted.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 6; k++) tw[k] = SZER'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5 - i; j++)
            if (tw[j] > tw[j+1]) begin
              logic [SZER-1:0] t;
              t = tw[j]; tw[j] = tw[j+1]; tw[j+1] = t;
            end
      end
      tv   = ($urandom_range(0, 3) != 0);
      todb = ($urandom_range(0, 4) != 0);
      krok();
    end
    idle_cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
